// File: rtl/lsu_sram_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states and the access legality check.
`timescale 1ns/1ps
package lsu_sram_pkg;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;
   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   // Misaligned halfword/word or an unsupported funct3 never reaches the SRAM.
   function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic err;
      err = 1'b1;
      if (we) begin
         case (f3)
            SB:      err = 1'b0;
            SH:      err = off[0];
            SW:      err = |off;
            default: err = 1'b1;
         endcase
      end else begin
         case (f3)
            LB, LBU:  err = 1'b0;
            LH, LHU:  err = off[0];
            LW:       err = |off;
            default:  err = 1'b1;
         endcase
      end
      return err;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner: shifts the SRAM word down by the byte offset and sign/zero-extends.
`timescale 1ns/1ps
module lsu_load_align
   import lsu_sram_pkg::*;
(
   input  logic [31:0] i_dout,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_f3,
   output logic [31:0] o_rdata
);

   logic [31:0] w_s;

   always_comb begin
      w_s = i_dout >> {i_off, 3'b000};
      case (i_f3)
         LB:      o_rdata = {{24{w_s[7]}}, w_s[7:0]};
         LBU:     o_rdata = {24'h0, w_s[7:0]};
         LH:      o_rdata = {{16{w_s[15]}}, w_s[15:0]};
         LHU:     o_rdata = {16'h0, w_s[15:0]};
         default: o_rdata = w_s;
      endcase
   end

endmodule

// File: rtl/lsu_sram.sv
// Single-outstanding RV32 load/store unit driving an active-low SRAM port with registered strobes.
// Response 1+SRAM_LATENCY cycles after accept; req_ready only in IDLE/RESP, so requests are never queued.
`timescale 1ns/1ps
module lsu_sram
   import lsu_sram_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int SRAM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [2:0]        i_req_funct3,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_sram_cen,
   output logic              o_sram_wen,
   output logic [3:0]        o_sram_ben,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [31:0]       o_sram_din,
   input  logic [31:0]       i_sram_dout
);

   lsu_state_t        r_state;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [1:0]        r_off;
   logic              r_err;
   logic              r_sram_cen;
   logic              r_sram_wen;
   logic [3:0]        r_sram_ben;
   logic [ADDR_W-1:0] r_sram_addr;
   logic [31:0]       r_sram_din;

   logic              w_accept;
   logic              w_err;
   logic [1:0]        w_off;
   logic [3:0]        w_st_ben;
   logic [31:0]       w_st_din;
   logic [31:0]       w_load;

   assign o_req_ready = (r_state == IDLE) || (r_state == RESP);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_off       = i_req_addr[1:0];
   assign w_err       = access_err(i_req_we, i_req_funct3, w_off);

   always_comb begin
      w_st_ben = 4'h0;
      w_st_din = i_req_wdata;
      case (i_req_funct3)
         SB: begin
            w_st_ben = ~(4'b0001 << w_off);
            w_st_din = {4{i_req_wdata[7:0]}};
         end
         SH: begin
            w_st_ben = ~(4'b0011 << w_off);
            w_st_din = {2{i_req_wdata[15:0]}};
         end
         default: begin
            w_st_ben = 4'h0;
            w_st_din = i_req_wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_f3        <= 3'd0;
         r_off       <= 2'd0;
         r_err       <= 1'b0;
         r_sram_cen  <= 1'b1;
         r_sram_wen  <= 1'b1;
         r_sram_ben  <= 4'hF;
         r_sram_addr <= '0;
         r_sram_din  <= '0;
      end else begin
         // Strobes are a one-cycle pulse: idle unless an accept re-arms them below.
         r_sram_cen <= 1'b1;
         r_sram_wen <= 1'b1;
         r_sram_ben <= 4'hF;
         case (r_state)
            IDLE, RESP: r_state <= w_accept ? ACCESS : IDLE;
            ACCESS:     r_state <= (SRAM_LATENCY == 2) ? WAIT : RESP;
            WAIT:       r_state <= RESP;
            default:    r_state <= IDLE;
         endcase
         if (w_accept) begin
            r_we  <= i_req_we;
            r_f3  <= i_req_funct3;
            r_off <= w_off;
            r_err <= w_err;
            if (!w_err) begin
               r_sram_cen  <= 1'b0;
               r_sram_wen  <= ~i_req_we;
               r_sram_ben  <= i_req_we ? w_st_ben : 4'h0;
               r_sram_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
               if (i_req_we) begin
                  r_sram_din <= w_st_din;
               end
            end
         end
      end
   end

   lsu_load_align u_align (
      .i_dout  (i_sram_dout),
      .i_off   (r_off),
      .i_f3    (r_f3),
      .o_rdata (w_load)
   );

   assign o_sram_cen  = r_sram_cen;
   assign o_sram_wen  = r_sram_wen;
   assign o_sram_ben  = r_sram_ben;
   assign o_sram_addr = r_sram_addr;
   assign o_sram_din  = r_sram_din;

   assign o_rsp_valid = (r_state == RESP);
   assign o_rsp_err   = o_rsp_valid && r_err;
   assign o_rsp_rdata = (o_rsp_valid && !r_err && !r_we) ? w_load : 32'h0;

endmodule

// File: tb/tb_lsu_sram.sv
// Directed bench for lsu_sram: one instance at SRAM_LATENCY=1, one at SRAM_LATENCY=2, each with a small SRAM model.
`timescale 1ns/1ps
module tb_lsu_sram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v1, v2;
   logic        we_i;
   logic [2:0]  f3_i;
   logic [31:0] addr_i, wdata_i;

   logic        rdy1, rv1, err1, cen1, wen1;
   logic [31:0] rdata1, addr1, din1;
   logic [3:0]  ben1;
   logic [31:0] dout1 = 32'h0;

   logic        rdy2, rv2, err2, cen2, wen2;
   logic [31:0] rdata2, addr2, din2;
   logic [3:0]  ben2;
   logic [31:0] dout2 = 32'h0;
   logic [31:0] q2    = 32'h0;

   logic [31:0] mem1 [0:15];
   logic [31:0] mem2 [0:15];

   logic        s_cen, s_wen;
   logic [3:0]  s_ben;
   logic [31:0] s_addr, s_din;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   lsu_sram #(.ADDR_W(32), .SRAM_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(v1), .o_req_ready(rdy1), .i_req_we(we_i), .i_req_funct3(f3_i),
      .i_req_addr(addr_i), .i_req_wdata(wdata_i),
      .o_rsp_valid(rv1), .o_rsp_rdata(rdata1), .o_rsp_err(err1),
      .o_sram_cen(cen1), .o_sram_wen(wen1), .o_sram_ben(ben1), .o_sram_addr(addr1),
      .o_sram_din(din1), .i_sram_dout(dout1)
   );

   lsu_sram #(.ADDR_W(32), .SRAM_LATENCY(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(v2), .o_req_ready(rdy2), .i_req_we(we_i), .i_req_funct3(f3_i),
      .i_req_addr(addr_i), .i_req_wdata(wdata_i),
      .o_rsp_valid(rv2), .o_rsp_rdata(rdata2), .o_rsp_err(err2),
      .o_sram_cen(cen2), .o_sram_wen(wen2), .o_sram_ben(ben2), .o_sram_addr(addr2),
      .o_sram_din(din2), .i_sram_dout(dout2)
   );

   // SRAM models: byte-masked write, registered read (one extra stage for latency 2)
   always @(posedge clk) begin
      if (!cen1) begin
         if (!wen1) begin
            for (int b = 0; b < 4; b++)
               if (!ben1[b]) mem1[addr1[5:2]][8*b +: 8] <= din1[8*b +: 8];
         end else begin
            dout1 <= mem1[addr1[5:2]];
         end
      end
   end

   always @(posedge clk) begin
      if (!cen2) begin
         if (!wen2) begin
            for (int b = 0; b < 4; b++)
               if (!ben2[b]) mem2[addr2[5:2]][8*b +: 8] <= din2[8*b +: 8];
         end else begin
            q2 <= mem2[addr2[5:2]];
         end
      end
      dout2 <= q2;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated request on dut1: captures the ACCESS-cycle strobes, checks the RESP cycle.
   task automatic op(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      we_i = we; f3_i = f3; addr_i = addr; wdata_i = wdata; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      @(negedge clk);
      s_cen = cen1; s_wen = wen1; s_ben = ben1; s_addr = addr1; s_din = din1;
      chk({tag, ".busy_rdy"}, rdy1, 0);
      chk({tag, ".access_vld"}, rv1, 0);
      tick();
      @(negedge clk);
      chk({tag, ".rsp_vld"}, rv1, 1);
      chk({tag, ".rsp_err"}, err1, exp_err);
      chk({tag, ".rsp_rdata"}, rdata1, exp_rdata);
      chk({tag, ".resp_cen"}, cen1, 1);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0;
      we_i = 1'b0; f3_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
      tick(); tick();
      @(negedge clk);
      chk("rst.cen", cen1, 1);
      chk("rst.wen", wen1, 1);
      chk("rst.ben", ben1, 4'hF);
      chk("rst.addr", addr1, 0);
      chk("rst.din", din1, 0);
      chk("rst.rsp_vld", rv1, 0);
      chk("rst.rdata", rdata1, 0);
      chk("rst.err", err1, 0);
      chk("rst.rdy", rdy1, 1);
      chk("rst.rdy2", rdy2, 1);
      tick();
      rst_n = 1'b1;
      tick();

      op("sw0", 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      chk("sw0.cen", s_cen, 0);
      chk("sw0.wen", s_wen, 0);
      chk("sw0.ben", s_ben, 4'h0);
      chk("sw0.addr", s_addr, 32'h10);
      chk("sw0.din", s_din, 32'hDEADBEEF);

      op("sw1", 1, 3'd2, 32'h10, 32'h8070F0A5, 32'h0, 0);
      op("lb", 0, 3'd0, 32'h11, 32'h0, 32'hFFFFFFF0, 0);
      chk("lb.cen", s_cen, 0);
      chk("lb.wen", s_wen, 1);
      chk("lb.ben", s_ben, 4'h0);
      chk("lb.addr", s_addr, 32'h10);
      op("lbu", 0, 3'd4, 32'h11, 32'h0, 32'h000000F0, 0);
      op("lh", 0, 3'd1, 32'h12, 32'h0, 32'hFFFF8070, 0);
      op("lhu", 0, 3'd5, 32'h12, 32'h0, 32'h00008070, 0);

      op("sb", 1, 3'd0, 32'h13, 32'h000000AB, 32'h0, 0);
      chk("sb.ben", s_ben, 4'b0111);
      chk("sb.din", s_din, 32'hABABABAB);
      chk("sb.addr", s_addr, 32'h10);
      op("lw", 0, 3'd2, 32'h10, 32'h0, 32'hAB70F0A5, 0);

      op("lw_mis", 0, 3'd2, 32'h12, 32'h0, 32'h0, 1);
      chk("lw_mis.cen", s_cen, 1);
      chk("lw_mis.ben", s_ben, 4'hF);
      op("sh_mis", 1, 3'd1, 32'h11, 32'h1234, 32'h0, 1);
      chk("sh_mis.cen", s_cen, 1);
      chk("sh_mis.wen", s_wen, 1);
      op("ld_f3", 0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
      chk("ld_f3.cen", s_cen, 1);
      op("st_f3", 1, 3'd4, 32'h10, 32'h55, 32'h0, 1);
      chk("st_f3.cen", s_cen, 1);
      op("lw_after_err", 0, 3'd2, 32'h10, 32'h0, 32'hAB70F0A5, 0);

      // Back-to-back on dut1; the store fields offered during ACCESS must not be sampled early.
      we_i = 0; f3_i = 3'd4; addr_i = 32'h10; wdata_i = 32'h0; v1 = 1'b1;
      tick();
      we_i = 1; f3_i = 3'd2; addr_i = 32'h14; wdata_i = 32'h11223344;
      @(negedge clk);
      chk("b2b.a_rdy", rdy1, 0);
      chk("b2b.a_cen", cen1, 0);
      chk("b2b.a_wen", wen1, 1);
      chk("b2b.a_addr", addr1, 32'h10);
      tick();
      @(negedge clk);
      chk("b2b.a_vld", rv1, 1);
      chk("b2b.a_rdata", rdata1, 32'h000000A5);
      chk("b2b.resp_rdy", rdy1, 1);
      tick();
      v1 = 1'b0;
      @(negedge clk);
      chk("b2b.b_cen", cen1, 0);
      chk("b2b.b_wen", wen1, 0);
      chk("b2b.b_addr", addr1, 32'h14);
      chk("b2b.b_din", din1, 32'h11223344);
      chk("b2b.b_gap_vld", rv1, 0);
      tick();
      @(negedge clk);
      chk("b2b.b_vld", rv1, 1);
      chk("b2b.b_rdata", rdata1, 32'h0);
      chk("b2b.b_err", err1, 0);
      tick();
      op("lw14", 0, 3'd2, 32'h14, 32'h0, 32'h11223344, 0);

      // Reset during ACCESS aborts the load.
      we_i = 0; f3_i = 3'd2; addr_i = 32'h10; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort.access_cen", cen1, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort.cen", cen1, 1);
      chk("abort.ben", ben1, 4'hF);
      chk("abort.vld", rv1, 0);
      chk("abort.rdy", rdy1, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         chk("abort.no_rsp", rv1, 0);
      end
      tick();

      // dut2 (latency 2): SW then LW to the same word, offered back-to-back.
      we_i = 1; f3_i = 3'd2; addr_i = 32'h18; wdata_i = 32'hCAFEF00D; v2 = 1'b1;
      tick();
      we_i = 0; f3_i = 3'd2; addr_i = 32'h18; wdata_i = 32'h0;
      @(negedge clk);
      chk("l2.a_rdy", rdy2, 0);
      chk("l2.a_cen", cen2, 0);
      chk("l2.a_wen", wen2, 0);
      tick();
      @(negedge clk);
      chk("l2.wait_vld", rv2, 0);
      chk("l2.wait_rdy", rdy2, 0);
      chk("l2.wait_cen", cen2, 1);
      tick();
      @(negedge clk);
      chk("l2.a_vld", rv2, 1);
      chk("l2.a_err", err2, 0);
      chk("l2.a_rdata", rdata2, 32'h0);
      chk("l2.resp_rdy", rdy2, 1);
      tick();
      v2 = 1'b0;
      @(negedge clk);
      chk("l2.b_cen", cen2, 0);
      chk("l2.b_wen", wen2, 1);
      chk("l2.b_addr", addr2, 32'h18);
      chk("l2.b_access_vld", rv2, 0);
      tick();
      @(negedge clk);
      chk("l2.b_wait_vld", rv2, 0);
      tick();
      @(negedge clk);
      chk("l2.b_vld", rv2, 1);
      chk("l2.b_rdata", rdata2, 32'hCAFEF00D);
      chk("l2.b_err", err2, 0);
      tick();
      @(negedge clk);
      chk("l2.idle_vld", rv2, 0);
      chk("l2.idle_rdy", rdy2, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
